// File: rtl/img_stream_pkg.sv
// Shared definitions for the grey-pixel video stream (transmitter and future receiver/checker).
package img_stream_pkg;

  localparam int IMG_GRAY_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    VS_LEAD = 3'd1,
    LINE    = 3'd2,
    H_GAP   = 3'd3,
    VS_TAIL = 3'd4
  } img_tx_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/img_stream_tx.sv
// Frame transmitter: pulls grey pixels from a valid/ready source and emits one
// vsync/href/gray frame per start pulse with programmable lead, line gap and tail.
module img_stream_tx
  import img_stream_pkg::*;
#(
  parameter int IMG_H_DISP = 640,
  parameter int IMG_V_DISP = 480,
  parameter int V_FRONT    = 5,
  parameter int H_BLANK    = 5,
  parameter int V_BACK     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_s_valid,
  input  logic [IMG_GRAY_W-1:0] i_s_data,
  output logic                  o_s_ready,
  output logic                  o_img_vsync,
  output logic                  o_img_href,
  output logic [IMG_GRAY_W-1:0] o_img_gray,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_underrun
);

  localparam int COL_W = $clog2(IMG_H_DISP + 1);
  localparam int ROW_W = $clog2(IMG_V_DISP + 1);
  localparam int PH_W  = $clog2(max3(V_FRONT, H_BLANK, V_BACK) + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_H_DISP - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_V_DISP - 1);

  // vsync rises with the state, but href trails the LINE state by one cycle,
  // so the lead phase is one cycle shorter than V_FRONT and the tail one longer.
  localparam bit               HAS_LEAD  = (V_FRONT > 1);
  localparam logic [PH_W-1:0]  LEAD_LOAD = PH_W'((V_FRONT > 1) ? (V_FRONT - 2) : 0);
  localparam logic [PH_W-1:0]  GAP_LOAD  = PH_W'(H_BLANK - 1);
  localparam logic [PH_W-1:0]  TAIL_LOAD = PH_W'(V_BACK);

  img_tx_state_t r_state, w_state_next;

  logic [PH_W-1:0]       r_phase, w_phase_next;
  logic [COL_W-1:0]      r_col, w_col_next;
  logic [ROW_W-1:0]      r_row, w_row_next;
  logic                  r_vsync, w_vsync_next;
  logic                  r_href;
  logic [IMG_GRAY_W-1:0] r_gray;
  logic                  r_busy;
  logic                  r_frame_done, w_frame_done_next;
  logic                  r_underrun, w_underrun_next;
  logic                  w_ready;
  logic                  w_accept;

  assign w_ready  = (r_state == LINE);
  assign w_accept = w_ready && i_s_valid;

  always_comb begin
    w_state_next      = r_state;
    w_phase_next      = r_phase;
    w_col_next        = r_col;
    w_row_next        = r_row;
    w_vsync_next      = r_vsync;
    w_frame_done_next = 1'b0;
    w_underrun_next   = r_underrun;

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_underrun_next = 1'b0;
          w_col_next      = '0;
          w_row_next      = '0;
          w_vsync_next    = 1'b1;
          w_phase_next    = LEAD_LOAD;
          // A one-cycle lead is fully covered by the start edge itself.
          w_state_next    = HAS_LEAD ? VS_LEAD : LINE;
        end
      end

      VS_LEAD: begin
        if (r_phase == '0) begin
          w_state_next = LINE;
        end else begin
          w_phase_next = r_phase - PH_W'(1);
        end
      end

      LINE: begin
        if (w_accept) begin
          if (r_col == COL_LAST) begin
            w_col_next = '0;
            if (r_row == ROW_LAST) begin
              w_state_next = VS_TAIL;
              w_phase_next = TAIL_LOAD;
            end else begin
              w_state_next = H_GAP;
              w_phase_next = GAP_LOAD;
            end
          end else begin
            w_col_next = r_col + COL_W'(1);
          end
        end else begin
          w_underrun_next = 1'b1;
        end
      end

      H_GAP: begin
        if (r_phase == '0) begin
          w_state_next = LINE;
          w_row_next   = r_row + ROW_W'(1);
        end else begin
          w_phase_next = r_phase - PH_W'(1);
        end
      end

      VS_TAIL: begin
        if (r_phase == '0) begin
          w_state_next      = IDLE;
          w_vsync_next      = 1'b0;
          w_frame_done_next = 1'b1;
        end else begin
          w_phase_next = r_phase - PH_W'(1);
        end
      end

      default: begin
        w_state_next = IDLE;
        w_vsync_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_phase      <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_gray       <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_phase      <= w_phase_next;
      r_col        <= w_col_next;
      r_row        <= w_row_next;
      r_vsync      <= w_vsync_next;
      r_href       <= w_accept;
      r_busy       <= (w_state_next != IDLE);
      r_frame_done <= w_frame_done_next;
      r_underrun   <= w_underrun_next;
      if (w_accept) begin
        r_gray <= i_s_data;
      end
    end
  end

  assign o_s_ready    = w_ready;
  assign o_img_vsync  = r_vsync;
  assign o_img_href   = r_href;
  assign o_img_gray   = r_gray;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_underrun   = r_underrun;

endmodule
